// File: rtl/drive_cmd_gen_pkg.sv
// Shared constants and FSM state type for the drive command generator.
package drive_pkg;

  localparam int CMD_MAX   = 1023;
  localparam int CORR_MAX  = 511;
  localparam int INTEG_MAX = 16383;

  localparam int CMD_W   = 11;
  localparam int SPD_W   = 10;
  localparam int INTEG_W = 15;

  typedef enum logic [2:0] {
    IDLE,
    PTERM,
    ITERM,
    SUM,
    OUT
  } state_t;

endpackage

// File: rtl/drive_cmd_gen_if.sv
// Sample-in / drive-command-out bundle of the drive command generator.
interface drive_cmd_gen_if;
  import drive_pkg::*;

  logic                    go;
  logic [SPD_W-1:0]        fwd_spd;
  logic signed [CMD_W-1:0] err;
  logic                    err_vld;
  logic signed [CMD_W-1:0] lft;
  logic signed [CMD_W-1:0] rht;
  logic                    cmd_vld;
  logic                    busy;
  logic                    ovr;

  modport master (
    output go, fwd_spd, err, err_vld,
    input  lft, rht, cmd_vld, busy, ovr
  );

  modport slave (
    input  go, fwd_spd, err, err_vld,
    output lft, rht, cmd_vld, busy, ovr
  );

endinterface

// File: rtl/drive_cmd_gen_sat_signed.sv
// Combinational clamp of a signed value to +/-LIMIT, narrowed to OUT_W bits.
module sat_signed #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 11,
  parameter int LIMIT = 1023
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] HI = IN_W'(LIMIT);
  localparam logic signed [IN_W-1:0] LO = IN_W'(-LIMIT);

  // Symmetric limits keep the most negative code of OUT_W out of the result.
  always_comb begin
    if (din > HI) begin
      dout = OUT_W'(HI);
    end else if (din < LO) begin
      dout = OUT_W'(LO);
    end else begin
      dout = OUT_W'(din);
    end
  end

endmodule

// File: rtl/drive_cmd_gen.sv
// PI steering controller producing left/right drive commands over a 5-cycle sequence.
// Optional output slew limiting is enabled by defining SLEW_LIMIT_EN.
module drive_cmd_gen
  import drive_pkg::*;
#(
  parameter int KP        = 2,
  parameter int KI_SHIFT  = 5,
  parameter int SLEW_STEP = 64
) (
  input logic            clk,
  input logic            rst_n,
  drive_cmd_gen_if.slave bus
);

  if (KP < 1 || KP > 15 || KI_SHIFT < 0 || SLEW_STEP < 1) begin : g_param_check
    $error("drive_cmd_gen: parameter out of range");
  end

  state_t state, next_state;

  logic signed [CMD_W-1:0]   err_q;
  logic [SPD_W-1:0]          spd_q;
  logic signed [CMD_W-1:0]   p_q;
  logic signed [INTEG_W-1:0] integ_q;
  logic                      sat_flag;
  logic signed [CMD_W-1:0]   lft_q, rht_q;
  logic                      cmd_vld_q, ovr_q, busy;

  logic signed [INTEG_W-1:0] prod, integ_sat, i_term;
  logic signed [INTEG_W:0]   integ_sum, corr_sum;
  logic signed [CMD_W-1:0]   p_sat, corr, lft_tgt, rht_tgt, lft_nxt, rht_nxt;
  logic signed [CMD_W:0]     spd_ext, lft_sum, rht_sum;
  logic                      clip;

  assign prod      = INTEG_W'(err_q * KP);
  assign integ_sum = (INTEG_W+1)'(integ_q) + (INTEG_W+1)'(err_q);
  assign i_term    = integ_q >>> KI_SHIFT;
  assign corr_sum  = (INTEG_W+1)'(p_q) + (INTEG_W+1)'(i_term);
  assign spd_ext   = $signed({{(CMD_W+1-SPD_W){1'b0}}, spd_q});
  assign lft_sum   = spd_ext + (CMD_W+1)'(corr);
  assign rht_sum   = spd_ext - (CMD_W+1)'(corr);

  sat_signed #(.IN_W(INTEG_W),   .OUT_W(CMD_W),   .LIMIT(CORR_MAX))  u_sat_p     (.din(prod),      .dout(p_sat));
  sat_signed #(.IN_W(INTEG_W+1), .OUT_W(INTEG_W), .LIMIT(INTEG_MAX)) u_sat_integ (.din(integ_sum), .dout(integ_sat));
  sat_signed #(.IN_W(INTEG_W+1), .OUT_W(CMD_W),   .LIMIT(CORR_MAX))  u_sat_corr  (.din(corr_sum),  .dout(corr));
  sat_signed #(.IN_W(CMD_W+1),   .OUT_W(CMD_W),   .LIMIT(CMD_MAX))   u_sat_lft   (.din(lft_sum),   .dout(lft_tgt));
  sat_signed #(.IN_W(CMD_W+1),   .OUT_W(CMD_W),   .LIMIT(CMD_MAX))   u_sat_rht   (.din(rht_sum),   .dout(rht_tgt));

  // Clipping is judged on the unslewed targets so anti-windup tracks the true demand.
  assign clip = ((CMD_W+1)'(lft_tgt) != lft_sum) || ((CMD_W+1)'(rht_tgt) != rht_sum);

`ifdef SLEW_LIMIT_EN
  function automatic logic signed [CMD_W-1:0] slew(input logic signed [CMD_W-1:0] prev,
                                                   input logic signed [CMD_W-1:0] target);
    logic signed [CMD_W:0] step, delta;
    step  = (CMD_W+1)'(SLEW_STEP);
    delta = (CMD_W+1)'(target) - (CMD_W+1)'(prev);
    if (delta > step) begin
      slew = CMD_W'((CMD_W+1)'(prev) + step);
    end else if (delta < -step) begin
      slew = CMD_W'((CMD_W+1)'(prev) - step);
    end else begin
      slew = target;
    end
  endfunction

  assign lft_nxt = slew(lft_q, lft_tgt);
  assign rht_nxt = slew(rht_q, rht_tgt);
`else
  assign lft_nxt = lft_tgt;
  assign rht_nxt = rht_tgt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    if (!bus.go) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.err_vld) next_state = PTERM;
        PTERM:   next_state = ITERM;
        ITERM:   next_state = SUM;
        SUM:     next_state = OUT;
        OUT:     next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs load on the edge into OUT, so new commands appear together with cmd_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= '0;
      spd_q     <= '0;
      p_q       <= '0;
      integ_q   <= '0;
      sat_flag  <= 1'b0;
      lft_q     <= '0;
      rht_q     <= '0;
      cmd_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else if (!bus.go) begin
      integ_q   <= '0;
      sat_flag  <= 1'b0;
      lft_q     <= '0;
      rht_q     <= '0;
      cmd_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      cmd_vld_q <= 1'b0;
      ovr_q     <= bus.err_vld && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.err_vld) begin
            err_q <= bus.err;
            spd_q <= bus.fwd_spd;
          end
        end
        PTERM: p_q <= p_sat;
        ITERM: if (!sat_flag) integ_q <= integ_sat;
        SUM: begin
          lft_q     <= lft_nxt;
          rht_q     <= rht_nxt;
          sat_flag  <= clip;
          cmd_vld_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.lft     = lft_q;
  assign bus.rht     = rht_q;
  assign bus.cmd_vld = cmd_vld_q;
  assign bus.busy    = busy;
  assign bus.ovr     = ovr_q;

endmodule

// File: tb/tb_drive_cmd_gen.sv
// Directed self-checking bench for drive_cmd_gen (KP=2, KI_SHIFT=5, SLEW_STEP=64).
module tb_drive_cmd_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

`ifdef SLEW_LIMIT_EN
  localparam int EXP_L = 64,  EXP_R = 64,  EXPB_L = 128, EXPB_R = 128;
`else
  localparam int EXP_L = 603, EXP_R = 197, EXPB_L = 606, EXPB_R = 194;
`endif

  always #5 clk = ~clk;

  drive_cmd_gen_if bus ();

  drive_cmd_gen #(.KP(2), .KI_SHIFT(5), .SLEW_STEP(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one sample now (cycle 0), ends in cycle 5 with cycle-4 outputs captured.
  task automatic run_sample(input int spd, input int e, output logic signed [10:0] l,
                            output logic signed [10:0] r, output int pulses, output logic vld4);
    bus.go = 1'b1; bus.fwd_spd = 10'(spd); bus.err = 11'(e); bus.err_vld = 1'b1;
    tick();
    bus.err_vld = 1'b0;
    pulses = 0; l = '0; r = '0; vld4 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (bus.cmd_vld) pulses++;
      if (c == 4) begin l = bus.lft; r = bus.rht; vld4 = bus.cmd_vld; end
      if (c < 5) tick();
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; bus.go = 1'b0; bus.err_vld = 1'b0;
    #3;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.go = 1'b0; bus.err_vld = 1'b0; bus.err = '0; bus.fwd_spd = '0;
    #2;
    checks++;
    if (bus.lft !== 11'sd0 || bus.rht !== 11'sd0) begin
      failures++; $display("[TB] FAIL reset_cmd: lft=%0d rht=%0d expected 0 0", bus.lft, bus.rht);
    end
    checks++;
    if ({bus.cmd_vld, bus.busy, bus.ovr} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_flags: vld/busy/ovr=%b expected 000", {bus.cmd_vld, bus.busy, bus.ovr});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic signed [10:0] l, r; int p; logic v;
    run_sample(400, 100, l, r, p, v);
    checks++;
    if (p !== 1 || v !== 1'b1) begin failures++; $display("[TB] FAIL basic_vld: pulses=%0d at4=%b expected 1 1", p, v); end
    checks++;
    if (l !== 11'(EXP_L)) begin failures++; $display("[TB] FAIL basic_lft: got %0d expected %0d", l, EXP_L); end
    checks++;
    if (r !== 11'(EXP_R)) begin failures++; $display("[TB] FAIL basic_rht: got %0d expected %0d", r, EXP_R); end
  endtask

  task automatic test_reset_mid_out();
    bus.go = 1'b1; bus.fwd_spd = 10'd400; bus.err = 11'sd100; bus.err_vld = 1'b1;
    tick();
    bus.err_vld = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus.cmd_vld !== 1'b1) begin failures++; $display("[TB] FAIL midout_pre_vld: got %b expected 1", bus.cmd_vld); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.lft !== 11'sd0 || bus.rht !== 11'sd0) begin
      failures++; $display("[TB] FAIL midout_cmd: lft=%0d rht=%0d expected 0 0", bus.lft, bus.rht);
    end
    checks++;
    if (bus.cmd_vld !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("[TB] FAIL midout_flags: vld=%b busy=%b expected 0 0", bus.cmd_vld, bus.busy);
    end
    bus.go = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    logic signed [10:0] l, r; int p; logic v;
    for (int k = 0; k < 2; k++) begin
      run_sample(1023, -1024, l, r, p, v);
      checks++;
      if (p !== 1 || v !== 1'b1) begin failures++; $display("[TB] FAIL sat_vld%0d: pulses=%0d at4=%b expected 1 1", k, p, v); end
      checks++;
      if (l !== 11'sd512) begin failures++; $display("[TB] FAIL sat_lft%0d: got %0d expected 512", k, l); end
      checks++;
      if (r !== 11'sd1023) begin failures++; $display("[TB] FAIL sat_rht%0d: got %0d expected 1023", k, r); end
    end
    // Frozen integrator (-1024) gives I=-32; a windup to -2048 would give lft=448.
    run_sample(512, 0, l, r, p, v);
    checks++;
    if (l !== 11'sd480) begin failures++; $display("[TB] FAIL windup_lft: got %0d expected 480", l); end
    checks++;
    if (r !== 11'sd544) begin failures++; $display("[TB] FAIL windup_rht: got %0d expected 544", r); end
  endtask

  task automatic test_neg_limit();
    logic signed [10:0] l, r; int p; logic v;
    run_sample(0, 1023, l, r, p, v);
    checks++;
    if (p !== 1 || v !== 1'b1) begin failures++; $display("[TB] FAIL neg_vld: pulses=%0d at4=%b expected 1 1", p, v); end
    checks++;
    if (l !== 11'sd511) begin failures++; $display("[TB] FAIL neg_lft: got %0d expected 511", l); end
    checks++;
    if (r !== -11'sd511) begin failures++; $display("[TB] FAIL neg_rht: got %0d expected -511", r); end
  endtask

  task automatic test_overrun();
    bus.go = 1'b1; bus.fwd_spd = 10'd400; bus.err = 11'sd100; bus.err_vld = 1'b1;
    tick();
    bus.err_vld = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL ovr_busy: got %b expected 1", bus.busy); end
    tick();
    checks++;
    if (bus.ovr !== 1'b0) begin failures++; $display("[TB] FAIL ovr_early: got %b expected 0", bus.ovr); end
    bus.err_vld = 1'b1; bus.err = -11'sd500; bus.fwd_spd = 10'd0;
    tick();
    bus.err_vld = 1'b0;
    checks++;
    if (bus.ovr !== 1'b1 || bus.cmd_vld !== 1'b0) begin
      failures++; $display("[TB] FAIL ovr_pulse: ovr=%b vld=%b expected 1 0", bus.ovr, bus.cmd_vld);
    end
    tick();
    checks++;
    if (bus.cmd_vld !== 1'b1 || bus.ovr !== 1'b0) begin
      failures++; $display("[TB] FAIL ovr_vld: vld=%b ovr=%b expected 1 0", bus.cmd_vld, bus.ovr);
    end
    checks++;
    if (bus.lft !== 11'(EXP_L) || bus.rht !== 11'(EXP_R)) begin
      failures++; $display("[TB] FAIL ovr_cmd: lft=%0d rht=%0d expected %0d %0d", bus.lft, bus.rht, EXP_L, EXP_R);
    end
    tick();
    checks++;
    if (bus.cmd_vld !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("[TB] FAIL ovr_idle: vld=%b busy=%b expected 0 0", bus.cmd_vld, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [10:0] l, r; int p; logic v;
    run_sample(400, 100, l, r, p, v);
    checks++;
    if (p !== 1 || v !== 1'b1) begin failures++; $display("[TB] FAIL b2b_vld: pulses=%0d at4=%b expected 1 1", p, v); end
    checks++;
    if (l !== 11'(EXPB_L) || r !== 11'(EXPB_R)) begin
      failures++; $display("[TB] FAIL b2b_cmd: lft=%0d rht=%0d expected %0d %0d", l, r, EXPB_L, EXPB_R);
    end
  endtask

  task automatic test_go_drop();
    logic signed [10:0] l, r; int p; logic v; int pulses;
    bus.go = 1'b1; bus.fwd_spd = 10'd400; bus.err = 11'sd100; bus.err_vld = 1'b1;
    tick();
    bus.err_vld = 1'b0;
    tick();
    bus.go = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.lft !== 11'sd0 || bus.rht !== 11'sd0) begin
      failures++; $display("[TB] FAIL go_drop: busy=%b lft=%0d rht=%0d expected 0 0 0", bus.busy, bus.lft, bus.rht);
    end
    pulses = bus.cmd_vld ? 1 : 0;
    bus.err_vld = 1'b1;
    tick();
    checks++;
    if (bus.ovr !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("[TB] FAIL go_low_ignore: ovr=%b busy=%b expected 0 0", bus.ovr, bus.busy);
    end
    for (int c = 0; c < 4; c++) begin
      if (bus.cmd_vld) pulses++;
      tick();
    end
    bus.err_vld = 1'b0;
    checks++;
    if (pulses !== 0) begin failures++; $display("[TB] FAIL go_drop_vld: pulses=%0d expected 0", pulses); end
    run_sample(400, 100, l, r, p, v);
    checks++;
    if (p !== 1 || v !== 1'b1) begin failures++; $display("[TB] FAIL rego_vld: pulses=%0d at4=%b expected 1 1", p, v); end
    checks++;
    if (l !== 11'(EXP_L) || r !== 11'(EXP_R)) begin
      failures++; $display("[TB] FAIL rego_cmd: lft=%0d rht=%0d expected %0d %0d", l, r, EXP_L, EXP_R);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_out();
`ifndef SLEW_LIMIT_EN
    test_saturation();
    apply_reset();
    test_neg_limit();
    apply_reset();
`endif
    test_overrun();
    test_back_to_back();
    test_go_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
